// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the programmable countdown timer.
// The up-counter in the same control datapath uses this package as well.
package countdown_timer_pkg;

  localparam int TIMER_WIDTH_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } timer_state_t;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer_if.sv
// Control and status bundle between a timer client (master) and the countdown timer (slave).
import countdown_timer_pkg::*;

interface countdown_timer_if #(parameter int WIDTH = TIMER_WIDTH_DEFAULT);

  logic [WIDTH-1:0] data;
  logic             load;
  logic             start;
  logic             stop;
  logic             enable;
  logic             reload_en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output data, load, start, stop, enable, reload_en,
    input  count, busy, done, zero
  );

  modport slave (
    input  data, load, start, stop, enable, reload_en,
    output count, busy, done, zero
  );

endinterface : countdown_timer_if

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop control, a one-cycle done pulse on expiry
// and optional auto-reload for periodic ticks. All outputs are registered.
import countdown_timer_pkg::*;

module countdown_timer #(
  parameter int WIDTH = TIMER_WIDTH_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  countdown_timer_if.slave tif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_t     state_q;
  timer_state_t     state_nxt;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_nxt;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;

  // Priority chain: load beats stop beats start beats enable; reset is handled in the register block.
  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count_q;
    reload_nxt = reload_q;

    if (tif.load) begin
      count_nxt  = tif.data;
      reload_nxt = tif.data;
      state_nxt  = IDLE;
    end else if (tif.stop) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (tif.start) begin
            state_nxt = (count_q != '0) ? RUN : EXPIRE;
          end
        end
        RUN: begin
          if (tif.enable && (count_q != '0)) begin
            count_nxt = count_q - ONE;
            if (count_q == ONE) begin
              state_nxt = EXPIRE;
            end
          end
        end
        EXPIRE: begin
          if (tif.reload_en && (reload_q != '0)) begin
            count_nxt = reload_q;
            state_nxt = RUN;
          end else begin
            count_nxt = '0;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Status flags are derived from the next state/count so they change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_nxt;
      count_q  <= count_nxt;
      reload_q <= reload_nxt;
      busy_q   <= (state_nxt == RUN);
      done_q   <= (state_nxt == EXPIRE);
      zero_q   <= (count_nxt == '0);
    end
  end

  assign tif.count = count_q;
  assign tif.busy  = busy_q;
  assign tif.done  = done_q;
  assign tif.zero  = zero_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed scenarios with literal expectations plus a randomized run, both
// checked every cycle against a behavioural model of the countdown timer.
module tb_countdown_timer;

  localparam int W = 5;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  countdown_timer_if #(.WIDTH(W)) tif ();

  countdown_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .tif (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 = waiting, 1 = counting, 2 = expiry cycle.
  int   m_mode;
  int   m_count;
  int   m_reload;
  bit   m_valid;

  always @(posedge clk) begin
    if (rst) begin
      m_mode   = 0;
      m_count  = 0;
      m_reload = 0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      if (tif.load) begin
        m_count  = int'(tif.data);
        m_reload = int'(tif.data);
        m_mode   = 0;
      end else if (tif.stop) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (tif.start) m_mode = (m_count > 0) ? 1 : 2;
      end else if (m_mode == 1) begin
        if (tif.enable && m_count > 0) begin
          m_count = m_count - 1;
          if (m_count == 0) m_mode = 2;
        end
      end else begin
        if (tif.reload_en && m_reload > 0) begin
          m_count = m_reload;
          m_mode  = 1;
        end else begin
          m_count = 0;
          m_mode  = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_checks++;
      if (int'(tif.count) != m_count) begin
        n_fail++;
        $display("[TB] FAIL model_count t=%0t actual=%0d expected=%0d", $time, tif.count, m_count);
      end
      n_checks++;
      if (tif.busy != (m_mode == 1)) begin
        n_fail++;
        $display("[TB] FAIL model_busy t=%0t actual=%0b expected=%0b", $time, tif.busy, (m_mode == 1));
      end
      n_checks++;
      if (tif.done != (m_mode == 2)) begin
        n_fail++;
        $display("[TB] FAIL model_done t=%0t actual=%0b expected=%0b", $time, tif.done, (m_mode == 2));
      end
      n_checks++;
      if (tif.zero != (m_count == 0)) begin
        n_fail++;
        $display("[TB] FAIL model_zero t=%0t actual=%0b expected=%0b", $time, tif.zero, (m_count == 0));
      end
    end
  end

  // Drives one cycle of inputs, waits for the edge, and leaves outputs settled for checking.
  task automatic applyStimulus(input bit r, input bit ld, input int d, input bit st,
                               input bit sp, input bit en, input bit re);
    rst           = r;
    tif.load      = ld;
    tif.data      = W'(d);
    tif.start     = st;
    tif.stop      = sp;
    tif.enable    = en;
    tif.reload_en = re;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int exp_count, input bit exp_busy,
                             input bit exp_done, input bit exp_zero);
    n_checks++;
    if (int'(tif.count) != exp_count || tif.busy != exp_busy ||
        tif.done != exp_done || tif.zero != exp_zero) begin
      n_fail++;
      $display("[TB] FAIL %s actual count=%0d busy=%0b done=%0b zero=%0b expected count=%0d busy=%0b done=%0b zero=%0b",
               name, tif.count, tif.busy, tif.done, tif.zero, exp_count, exp_busy, exp_done, exp_zero);
    end
  endtask

  int exp_en[5]     = '{2, 2, 1, 1, 0};
  int exp_reload[9] = '{1, 0, 2, 1, 0, 2, 1, 0, 2};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_valid  = 1'b0;
    rst = 1'b1; tif.load = 1'b0; tif.data = '0; tif.start = 1'b0;
    tif.stop = 1'b0; tif.enable = 1'b0; tif.reload_en = 1'b0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("reset", 0, 0, 0, 1);

    // Load 5, start, enable held high
    applyStimulus(0, 1, 5, 0, 0, 0, 0);
    checkOutput("load5", 5, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    checkOutput("start5", 5, 1, 0, 0);
    for (int k = 4; k >= 1; k--) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("run5", k, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("expire5", 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("after5", 0, 0, 0, 1);

    // Load 3, enable toggling
    applyStimulus(0, 1, 3, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("start3", 3, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, 0, (k % 2) == 0, 0);
      checkOutput("toggle3", exp_en[k], exp_en[k] != 0, exp_en[k] == 0, exp_en[k] == 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("after3", 0, 0, 0, 1);

    // Load 2 with auto-reload: period 3
    applyStimulus(0, 1, 2, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1, 1);
    checkOutput("start_reload", 2, 1, 0, 0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 1);
      checkOutput("reload", exp_reload[k], exp_reload[k] != 0, exp_reload[k] == 0, exp_reload[k] == 0);
    end

    // Load 0 then start: immediate expiry, never busy
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("load0", 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    checkOutput("zero_start", 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("zero_after", 0, 0, 0, 1);

    // Load 7, three decrements, stop, then resume
    applyStimulus(0, 1, 7, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("pre_stop", 4, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("stop", 4, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    checkOutput("resume", 4, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("resume_dec", 3, 1, 0, 0);

    // Load 9 with start mid-run: load wins
    applyStimulus(0, 1, 9, 1, 0, 1, 0);
    checkOutput("load_vs_start", 9, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("load_idle", 9, 0, 0, 0);

    // Reset during the expiry cycle
    applyStimulus(0, 1, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkOutput("expire1", 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 1);
    checkOutput("rst_expire", 0, 0, 0, 1);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 19) == 0,
                    d,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 9) < 7,
                    $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_countdown_timer
